uart_rx: RTL and testbench

//  Receive side of the console UART link; mates with uart_tx and shares its framing: 8N1, LSB first, line idles high.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync2.sv | 24 ++
 rtl/uart_rx.sv | 105 ++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the console UART receiver: frame width and receiver state encodings.
// The data-bit count is the same constant the transmitter uses, so both ends agree on framing.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  // Timer value at which the start bit is re-checked: the middle of the bit.
  function automatic int half_bit(input int clk_per_bit);
    return clk_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
// master is the receiver, slave is whatever drives the pin and consumes the bytes.
interface uart_rx_if;

  logic                                    serial;
  logic [uart_rx_pkg::UART_DATA_BITS-1:0]  data;
  logic                                    data_valid;
  logic                                    frame_error;
  logic                                    busy;

  modport master (
    input  serial,
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output serial,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
// Reusable for any slow async pin; the receiver resets it to the idle-high line level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start bit, samples each bit at mid-period
// and emits a one-cycle data_valid or frame_error strobe per frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_PER_BIT = 100
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_if.master    rx
);

  localparam int                 CNT_W   = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]   HALF_M1 = CNT_W'(half_bit(CLK_PER_BIT) - 1);
  localparam logic [CNT_W-1:0]   BIT_M1  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   FLUSH   = CNT_W'(2);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  logic                        rx_s;
  logic [2:0]                  state;
  logic [2:0]                  state_nxt;
  logic [CNT_W-1:0]            cnt;
  logic [BIT_IDX_W-1:0]        bit_cnt;
  logic [UART_DATA_BITS-1:0]   shift;
  logic [UART_DATA_BITS-1:0]   data_q;
  logic                        data_valid_q;
  logic                        frame_error_q;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.serial),
    .q   (rx_s)
  );

  wire bit_end = (cnt == BIT_M1);

  // WAIT_IDLE also lets the synchronizer flush for two cycles: its reset value of 1 says
  // nothing about the real line, and trusting it after a mid-frame reset would lock onto a data bit.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_WAIT_IDLE: if (rx_s && cnt == FLUSH) state_nxt = ST_IDLE;
      ST_IDLE:      if (!rx_s)                state_nxt = ST_START;
      ST_START:     if (cnt == HALF_M1)       state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_end && bit_cnt == LAST_BIT) state_nxt = ST_STOP;
      ST_STOP:      if (bit_end)              state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      default:                                state_nxt = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_WAIT_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      // NOTE: the shift register is reset along with the control state so data is never X.
      shift         <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
      state         <= state_nxt;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (state == ST_WAIT_IDLE) begin
        if (cnt != FLUSH) cnt <= cnt + CNT_W'(1);
      end else if (state == ST_DATA && bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_START) bit_cnt <= '0;

      // LSB arrives first, so each new bit enters at the top and the byte settles in place.
      if (state == ST_DATA && bit_end) begin
        shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BIT_IDX_W'(1);
      end

      if (state == ST_STOP && bit_end) begin
        if (rx_s) begin
          data_q       <= shift;
          data_valid_q <= 1'b1;
        end else begin
          frame_error_q <= 1'b1;
        end
      end
    end
  end

  assign rx.data        = data_q;
  assign rx.data_valid  = data_valid_q;
  assign rx.frame_error = frame_error_q;
  assign rx.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a behavioural serial transmitter queues the expected
// outcome of each frame; per-receiver monitors pop and compare whenever a strobe appears.
module tb_uart_rx;

  localparam int CLK_T   = 100;
  localparam int BT_A    = 100 * CLK_T;
  localparam int BT_B    = 16 * CLK_T;
  localparam int BT_FAST = BT_B * 97 / 100;
  localparam int BT_SLOW = BT_B * 103 / 100;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_good [2];
  bit         prev_a = 1'b0;
  bit         prev_b = 1'b0;

  uart_rx_if ifa ();
  uart_rx_if ifb ();

  uart_rx #(.CLK_PER_BIT(100)) dut_a (.clk(clk), .rst(rst_a), .rx(ifa.master));
  uart_rx #(.CLK_PER_BIT(16))  dut_b (.clk(clk), .rst(rst_b), .rx(ifb.master));

  always #(CLK_T / 2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) ifb.serial = v;
    else     ifa.serial = v;
  endtask

  task automatic idle(input bit sel, input int cycles);
    drive(sel, 1'b1);
    if (cycles > 0) #(cycles * CLK_T);
  endtask

  // A good stop bit delivers the byte; a low stop bit flags an error and leaves the
  // previously delivered byte on data.
  task automatic send_frame(input bit sel, input logic [7:0] b, input bit stop,
                            input int bt, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.err  = ~stop;
      e.data = stop ? b : last_good[sel];
      if (stop) last_good[sel] = b;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    drive(sel, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      #(bt);
    end
    drive(sel, stop);
    #(bt);
  endtask

  task automatic mon(input bit sel, input logic dv, input logic fe,
                     input logic [7:0] d, input bit prev);
    exp_t  e;
    string p = sel ? "b" : "a";
    int    pending = sel ? q_b.size() : q_a.size();
    check({"mutex_", p}, 32'(dv & fe), 32'(0));
    check({"strobe_width_", p}, 32'(prev), 32'(0));
    check({"strobe_expected_", p}, 32'(pending != 0), 32'(1));
    if (pending != 0) begin
      e = sel ? q_b.pop_front() : q_a.pop_front();
      check({"strobe_kind_", p}, 32'(fe), 32'(e.err));
      check({"data_", p}, 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (ifa.data_valid || ifa.frame_error)
      mon(1'b0, ifa.data_valid, ifa.frame_error, ifa.data, prev_a);
    prev_a = ifa.data_valid | ifa.frame_error;
  end

  always @(negedge clk) begin
    if (ifb.data_valid || ifb.frame_error)
      mon(1'b1, ifb.data_valid, ifb.frame_error, ifb.data, prev_b);
    prev_b = ifb.data_valid | ifb.frame_error;
  end

  task automatic wait_drain(input bit sel, input int max_cycles);
    int n = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "drain_b" : "drain_a", 32'(sel ? q_b.size() : q_a.size()), 32'(0));
  endtask

  initial begin
    logic [7:0] order [256];
    logic [7:0] tmp;
    int         j;
    bit         recovered;

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.serial = 1'b1;
    ifb.serial = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_data",        32'(ifa.data), 32'(0));
    check("reset_data_valid",  32'(ifa.data_valid), 32'(0));
    check("reset_frame_error", 32'(ifa.frame_error), 32'(0));
    check("reset_busy_a",      32'(ifa.busy), 32'(1));
    check("reset_busy_b",      32'(ifb.busy), 32'(1));
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy_a", 32'(ifa.busy), 32'(0));
    check("idle_busy_b", 32'(ifb.busy), 32'(0));

    // Single good frame.
    #($urandom_range(0, CLK_T - 1));
    send_frame(1'b0, 8'h63, 1'b1, BT_A, 1'b1);
    check("after_frame_busy", 32'(ifa.busy), 32'(0));
    check("after_frame_data", 32'(ifa.data), 32'(8'h63));
    wait_drain(1'b0, 10);

    // Short low glitch on an idle line must be rejected at the start-bit re-check.
    idle(1'b0, 50);
    drive(1'b0, 1'b0);
    #(20 * CLK_T);
    drive(1'b0, 1'b1);
    check("glitch_busy_high", 32'(ifa.busy), 32'(1));
    recovered = 1'b0;
    for (int i = 0; i < 55 && !recovered; i++) begin
      @(negedge clk);
      if (!ifa.busy) recovered = 1'b1;
    end
    check("glitch_recover", 32'(recovered), 32'(1));
    idle(1'b0, 100);

    // Bad stop bit followed by a long break, then a good frame.
    send_frame(1'b0, 8'hA5, 1'b0, BT_A, 1'b1);
    #(3000 * CLK_T);
    wait_drain(1'b0, 10);
    check("error_holds_data", 32'(ifa.data), 32'(last_good[0]));
    idle(1'b0, 50);
    send_frame(1'b0, 8'h3C, 1'b1, BT_A, 1'b1);
    idle(1'b0, 10);
    wait_drain(1'b0, 10);

    // Back-to-back frames with no idle gap.
    send_frame(1'b0, 8'h00, 1'b1, BT_A, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b1, BT_A, 1'b1);
    idle(1'b0, 20);
    wait_drain(1'b0, 10);

    // Reset during data bit 4: that frame is lost, data returns to zero.
    idle(1'b0, 100);
    fork
      send_frame(1'b0, 8'h81, 1'b1, BT_A, 1'b0);
      begin
        #(BT_A * 11 / 2);
        @(negedge clk);
        rst_a = 1'b1;
        last_good[0] = 8'h00;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
      end
    join
    idle(1'b0, 20);
    check("reset_midframe_data", 32'(ifa.data), 32'(last_good[0]));
    send_frame(1'b0, 8'h81, 1'b1, BT_A, 1'b1);
    idle(1'b0, 20);
    wait_drain(1'b0, 10);

    // Random frames with occasional bad stop bits.
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0), BT_A, 1'b1);
      idle(1'b0, $urandom_range(100, 300));
    end
    wait_drain(1'b0, 10);

    // Loopback at 16 clocks per bit: every byte value once, shuffled, small random gaps.
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      send_frame(1'b1, order[i], 1'b1, BT_B, 1'b1);
      idle(1'b1, $urandom_range(0, 20));
    end
    idle(1'b1, 20);
    wait_drain(1'b1, 50);

    // Transmitter 3% fast, then 3% slow.
    for (int i = 0; i < 32; i++) begin
      send_frame(1'b1, 8'($urandom), 1'b1, BT_FAST, 1'b1);
      idle(1'b1, $urandom_range(16, 40));
    end
    wait_drain(1'b1, 50);
    for (int i = 0; i < 32; i++) begin
      send_frame(1'b1, 8'($urandom), 1'b1, BT_SLOW, 1'b1);
      idle(1'b1, $urandom_range(16, 40));
    end
    wait_drain(1'b1, 50);
    wait_drain(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
